// File: rtl/cv32e40s_obi_arbiter.sv
// rtl/cv32e40s_obi_arbiter.sv - two-to-one OBI arbiter for instruction fetch and load/store.
module cv32e40s_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_i,
  output logic        inst_gnt_o,
  input  logic [31:0] inst_addr_i,
  output logic        inst_rvalid_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  input  logic        m_err_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  // Owner FIFO entry: 0 = instruction, 1 = data.
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wptr_q;
  logic [PW-1:0]              rptr_q;
  logic [CW-1:0]              cnt_q;
  logic                       lock_q;
  logic                       lock_owner_q;

  logic issue_ok;
  logic sel_inst;
  logic sel_data;
  logic hs;
  logic stall;
  logic resp;
  logic head;

  always_comb begin
    issue_ok = (cnt_q < CNT_MAX);
    sel_inst = 1'b0;
    sel_data = 1'b0;
    // A stalled request keeps the bus until granted so its payload stays stable.
    if (!rst) begin
      if (lock_q) begin
        sel_data = lock_owner_q;
        sel_inst = !lock_owner_q;
      end else if (issue_ok) begin
        sel_data = data_req_i;
        sel_inst = !data_req_i && inst_req_i;
      end
    end
  end

  always_comb begin
    m_req_o    = (sel_data && data_req_i) || (sel_inst && inst_req_i);
    hs         = m_req_o && m_gnt_i;
    stall      = m_req_o && !m_gnt_i;
    data_gnt_o = sel_data && hs;
    inst_gnt_o = sel_inst && hs;
    m_addr_o   = 32'h0;
    m_we_o     = 1'b0;
    m_be_o     = 4'h0;
    m_wdata_o  = 32'h0;
    if (sel_data) begin
      m_addr_o  = data_addr_i;
      m_we_o    = data_we_i;
      m_be_o    = data_be_i;
      m_wdata_o = data_wdata_i;
    end else if (sel_inst) begin
      m_addr_o  = inst_addr_i;
      m_be_o    = 4'hF;
    end
  end

  always_comb begin
    head          = fifo_q[rptr_q];
    resp          = !rst && m_rvalid_i && (cnt_q != '0);
    inst_rvalid_o = resp && !head;
    data_rvalid_o = resp && head;
    rdata_o       = rst ? 32'h0 : m_rdata_i;
    err_o         = !rst && m_err_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      if (hs) begin
        fifo_q[wptr_q] <= sel_data;
        wptr_q         <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        lock_q         <= 1'b0;
      end else if (stall) begin
        lock_q       <= 1'b1;
        lock_owner_q <= sel_data;
      end
      if (resp) begin
        rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      end
      if (hs && !resp) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!hs && resp) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40s_obi_arbiter.sv
// tb/tb_cv32e40s_obi_arbiter.sv - scoreboard bench for the OBI arbiter.
module tb_cv32e40s_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i, inst_gnt_o, inst_rvalid_o;
  logic [31:0] inst_addr_i;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        m_req_o, m_gnt_i, m_we_o, m_rvalid_i, m_err_i;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [3:0]  m_be_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic sb_owner[$];
  logic own;

  cv32e40s_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_gnt_o(inst_gnt_o), .inst_addr_i(inst_addr_i),
    .inst_rvalid_o(inst_rvalid_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
    .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .m_err_i(m_err_i)
  );

  always #5 clk = ~clk;

  // A locked requester must keep its request up until granted.
  always @(negedge clk) begin
    if (!rst && dut.lock_q)
      assert (dut.lock_owner_q ? data_req_i : inst_req_i)
        else $error("locked requester dropped its request");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req_i = 0; inst_addr_i = 0;
    data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_err_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    inst_req_i = 1; inst_addr_i = 32'h44; m_gnt_i = 1; m_rvalid_i = 1;
    step(); step();
    @(negedge clk);
    n_assert++;
    if ({m_req_o, inst_gnt_o, data_gnt_o, inst_rvalid_o, data_rvalid_o} !== 5'b0 || m_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_forced: req/gnt/rvalid=%b addr=%h, required 00000 and 0",
               {m_req_o, inst_gnt_o, data_gnt_o, inst_rvalid_o, data_rvalid_o}, m_addr_o);
    end
    step(); idle_inputs(); rst = 0;
    @(negedge clk);
    n_assert++;
    if ({m_req_o, inst_gnt_o, data_gnt_o, inst_rvalid_o, data_rvalid_o, err_o} !== 6'b0 ||
        m_addr_o !== 0 || m_be_o !== 0 || m_wdata_o !== 0 || m_we_o !== 0 || rdata_o !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_outputs: some output nonzero (req=%b addr=%h be=%h), required all 0",
               m_req_o, m_addr_o, m_be_o);
    end
    n_assert++;
    if (dut.cnt_q !== 0 || dut.lock_q !== 0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d lock=%b, required 0 0", dut.cnt_q, dut.lock_q);
    end
  endtask

  task automatic test_single_inst();
    step(); inst_req_i = 1; inst_addr_i = 32'h100; m_gnt_i = 1;
    @(negedge clk);
    n_assert++;
    if ({m_req_o, inst_gnt_o, data_gnt_o, m_we_o} !== 4'b1100 || m_addr_o !== 32'h100 || m_be_o !== 4'hF || m_wdata_o !== 0) begin
      n_fail++;
      $display("FAIL single_addr_phase: req/ig/dg/we=%b addr=%h be=%h, required 1100 100 f",
               {m_req_o, inst_gnt_o, data_gnt_o, m_we_o}, m_addr_o, m_be_o);
    end
    if (inst_gnt_o === 1'b1) sb_owner.push_back(1'b0);
    step(); inst_req_i = 0; m_gnt_i = 0;
    step(); m_rvalid_i = 1; m_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
    n_assert++;
    if ({inst_rvalid_o, data_rvalid_o} !== {!own, own} || rdata_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_response: irv/drv=%b rdata=%h, required %b deadbeef",
               {inst_rvalid_o, data_rvalid_o}, rdata_o, {!own, own});
    end
    step(); m_rvalid_i = 0;
  endtask

  task automatic test_simultaneous();
    inst_req_i = 1; inst_addr_i = 32'h104;
    data_req_i = 1; data_addr_i = 32'h200; data_we_i = 1; data_be_i = 4'h3; data_wdata_i = 32'h55AA;
    m_gnt_i = 1;
    @(negedge clk);
    n_assert++;
    if ({data_gnt_o, inst_gnt_o, m_we_o} !== 3'b101 || m_addr_o !== 32'h200 || m_be_o !== 4'h3 || m_wdata_o !== 32'h55AA) begin
      n_fail++;
      $display("FAIL simul_data_first: dg/ig/we=%b addr=%h be=%h wdata=%h, required 101 200 3 55aa",
               {data_gnt_o, inst_gnt_o, m_we_o}, m_addr_o, m_be_o, m_wdata_o);
    end
    sb_owner.push_back(1'b1);
    step(); data_req_i = 0;
    @(negedge clk);
    n_assert++;
    if ({inst_gnt_o, data_gnt_o} !== 2'b10 || m_addr_o !== 32'h104 || m_be_o !== 4'hF) begin
      n_fail++;
      $display("FAIL simul_inst_second: ig/dg=%b addr=%h be=%h, required 10 104 f",
               {inst_gnt_o, data_gnt_o}, m_addr_o, m_be_o);
    end
    sb_owner.push_back(1'b0);
    step(); inst_req_i = 0; m_gnt_i = 0;
    for (int i = 0; i < 2; i++) begin
      m_rvalid_i = 1; m_rdata_i = 32'hA100 + i;
      @(negedge clk);
      own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
      n_assert++;
      if ({inst_rvalid_o, data_rvalid_o} !== {!own, own} || rdata_o !== 32'hA100 + i) begin
        n_fail++;
        $display("FAIL simul_route_%0d: irv/drv=%b rdata=%h, required %b %h",
                 i, {inst_rvalid_o, data_rvalid_o}, rdata_o, {!own, own}, 32'hA100 + i);
      end
      step();
    end
    m_rvalid_i = 0;
  endtask

  task automatic test_lock_hold();
    inst_req_i = 1; inst_addr_i = 32'h100; m_gnt_i = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin data_req_i = 1; data_addr_i = 32'h300; data_we_i = 0; data_be_i = 4'hC; end
      if (c == 3) m_gnt_i = 1;
      @(negedge clk);
      n_assert++;
      if (m_addr_o !== 32'h100 || data_gnt_o !== 1'b0 || m_req_o !== 1'b1 || inst_gnt_o !== (c == 3)) begin
        n_fail++;
        $display("FAIL lock_hold_c%0d: addr=%h dg=%b ig=%b req=%b, required 100 0 %b 1",
                 c, m_addr_o, data_gnt_o, inst_gnt_o, m_req_o, c == 3);
      end
      if (c == 3 && inst_gnt_o === 1'b1) sb_owner.push_back(1'b0);
      step();
    end
    inst_req_i = 0;
    @(negedge clk);
    n_assert++;
    if (data_gnt_o !== 1'b1 || m_addr_o !== 32'h300 || m_be_o !== 4'hC) begin
      n_fail++;
      $display("FAIL lock_data_after: dg=%b addr=%h be=%h, required 1 300 c", data_gnt_o, m_addr_o, m_be_o);
    end
    sb_owner.push_back(1'b1);
    step(); data_req_i = 0; m_gnt_i = 0;
    for (int i = 0; i < 2; i++) begin
      m_rvalid_i = 1; m_rdata_i = 32'hB000 + i;
      @(negedge clk);
      own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
      n_assert++;
      if ({inst_rvalid_o, data_rvalid_o} !== {!own, own}) begin
        n_fail++;
        $display("FAIL lock_route_%0d: irv/drv=%b, required %b", i, {inst_rvalid_o, data_rvalid_o}, {!own, own});
      end
      step();
    end
    m_rvalid_i = 0;
  endtask

  task automatic test_full_stall();
    data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; m_gnt_i = 1;
    for (int c = 0; c < 6; c++) begin
      data_addr_i = 32'h400 + 4 * c;
      m_rvalid_i = (c == 4); m_rdata_i = 32'hC0;
      @(negedge clk);
      n_assert++;
      if ({m_req_o, data_gnt_o} !== (((c < 2) || (c == 5)) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL full_stall_c%0d: req/dg=%b, required %b", c, {m_req_o, data_gnt_o},
                 ((c < 2) || (c == 5)) ? 2'b11 : 2'b00);
      end
      if (data_gnt_o === 1'b1) sb_owner.push_back(1'b1);
      if (c == 4) begin
        own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
        n_assert++;
        if ({inst_rvalid_o, data_rvalid_o} !== {!own, own}) begin
          n_fail++;
          $display("FAIL full_rvalid: irv/drv=%b, required %b", {inst_rvalid_o, data_rvalid_o}, {!own, own});
        end
      end
      step();
      if (c == 5) begin data_req_i = 0; m_gnt_i = 0; end
    end
    for (int i = 0; i < 2; i++) begin
      m_rvalid_i = 1;
      @(negedge clk);
      own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
      n_assert++;
      if ({inst_rvalid_o, data_rvalid_o} !== {!own, own}) begin
        n_fail++;
        $display("FAIL full_drain_%0d: irv/drv=%b, required %b", i, {inst_rvalid_o, data_rvalid_o}, {!own, own});
      end
      step();
    end
    m_rvalid_i = 0;
  endtask

  task automatic test_push_pop_err();
    inst_req_i = 1; inst_addr_i = 32'h500; m_gnt_i = 1;
    @(negedge clk);
    if (inst_gnt_o === 1'b1) sb_owner.push_back(1'b0);
    step(); inst_req_i = 0;
    data_req_i = 1; data_addr_i = 32'h600; data_we_i = 0; data_be_i = 4'hF;
    m_rvalid_i = 1; m_err_i = 1; m_rdata_i = 32'hE0;
    @(negedge clk);
    own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
    n_assert++;
    if ({inst_rvalid_o, data_rvalid_o} !== {!own, own} || err_o !== 1'b1 || data_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_cycle: irv/drv=%b err=%b dg=%b, required %b 1 1",
               {inst_rvalid_o, data_rvalid_o}, err_o, data_gnt_o, {!own, own});
    end
    sb_owner.push_back(1'b1);
    step(); data_req_i = 0; m_gnt_i = 0; m_rvalid_i = 0; m_err_i = 0;
    @(negedge clk);
    n_assert++;
    if (dut.cnt_q !== 1 || dut.fifo_q[dut.rptr_q] !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_state: cnt=%0d head=%b, required 1 1", dut.cnt_q, dut.fifo_q[dut.rptr_q]);
    end
    step(); m_rvalid_i = 1;
    @(negedge clk);
    own = (sb_owner.size() != 0) ? sb_owner.pop_front() : 1'bx;
    n_assert++;
    if ({inst_rvalid_o, data_rvalid_o} !== {!own, own} || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_drain: irv/drv=%b err=%b, required %b 0", {inst_rvalid_o, data_rvalid_o}, err_o, {!own, own});
    end
    step(); m_rvalid_i = 0;
  endtask

  task automatic test_reset_mid();
    data_req_i = 1; data_addr_i = 32'h700; m_gnt_i = 1;
    step(); data_req_i = 0; inst_req_i = 1; inst_addr_i = 32'h704;
    step(); inst_req_i = 0; m_gnt_i = 0;
    n_assert++;
    if (dut.cnt_q !== 2) begin
      n_fail++;
      $display("FAIL resetmid_fill: cnt=%0d, required 2", dut.cnt_q);
    end
    rst = 1; m_rvalid_i = 1;
    @(negedge clk);
    n_assert++;
    if ({inst_rvalid_o, data_rvalid_o, m_req_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL resetmid_during: irv/drv/req=%b, required 000", {inst_rvalid_o, data_rvalid_o, m_req_o});
    end
    step(); rst = 0;
    sb_owner.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if (dut.cnt_q !== 0 || {inst_rvalid_o, data_rvalid_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL resetmid_stray_%0d: cnt=%0d irv/drv=%b, required 0 00", i, dut.cnt_q, {inst_rvalid_o, data_rvalid_o});
      end
      step();
    end
    m_rvalid_i = 0;
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_simultaneous();
    test_lock_hold();
    test_full_stall();
    test_push_pop_err();
    test_reset_mid();
    n_assert++;
    if (sb_owner.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb_owner.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_obi_arbiter.md
# cv32e40s_obi_arbiter

Two-to-one arbiter that shares a single OBI bus master port between the instruction-fetch and load/store requesters of the core. It carries the compressed OBI signal set: req/gnt address phase and in-order rvalid response phase. It is placed between the core's instruction and data interfaces and a single external memory port. A small owner FIFO tracks outstanding transactions so that in-order responses are routed back to the requester that issued them.

## Interface
- MAX_OUTSTANDING, 2: maximum granted-but-unresponded transactions, range 1..8; owner FIFO depth.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req_i / inst_gnt_o  in/out  1  instruction address-phase handshake
- inst_addr_i  in  32  instruction address (read-only requester)
- inst_rvalid_o  out  1  response valid for the instruction requester
- data_req_i / data_gnt_o  in/out  1  data address-phase handshake
- data_addr_i  in  32  data address
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid for the data requester
- rdata_o  out  32  response data, broadcast to both requesters (qualified by the per-port rvalid)
- err_o  out  1  response error, broadcast to both requesters
- m_req_o / m_gnt_i  out/in  1  shared-port address-phase handshake
- m_addr_o  out  32  shared-port address
- m_we_o  out  1  shared-port write enable
- m_be_o  out  4  shared-port byte enables
- m_wdata_o  out  32  shared-port write data
- m_rvalid_i  in  1  shared-port response valid
- m_rdata_i  in  32  shared-port response data
- m_err_i  in  1  shared-port response error

## Operation
- State:
  - owner FIFO of MAX_OUTSTANDING 1-bit entries (0=inst, 1=data);
  - cnt_q, width $clog2(MAX_OUTSTANDING+1);
  - lock_q and lock_owner_q.
- Issue allowed only when cnt_q < MAX_OUTSTANDING. There is no bypass on a same-cycle rvalid.
- Selection when lock_q=0 and issue allowed: data wins if data_req_i, else inst if inst_req_i, else none. Priority is fixed.
- Selection when lock_q=1: lock_owner_q, regardless of the other requester.
- m_req_o = selected requester's req_i.
- Payload muxing:
  - m_addr_o, m_we_o, m_be_o and m_wdata_o come from the selected requester.
  - Inst selected: m_we_o=0, m_be_o=4'hF, m_wdata_o=0.
  - Nothing selected: all payload outputs 0.
- Grant: the selected requester's gnt_o = m_req_o & m_gnt_i. The non-selected gnt_o = 0.
- Handshake (m_req_o & m_gnt_i):
  - push the selected owner into the FIFO;
  - clear lock_q.
- m_req_o=1 & m_gnt_i=0: set lock_q=1, lock_owner_q = selected. This satisfies the OBI rule that req and payload stay stable until gnt.
- While locked, a requester dropping req_i is a protocol violation; the bench flags it by assertion. RTL behaviour: m_req_o follows the owner's req_i and lock stays set.
- Response (m_rvalid_i & cnt_q != 0):
  - pop the FIFO head;
  - assert the head owner's rvalid_o;
  - rdata_o = m_rdata_i, err_o = m_err_i.
- m_rvalid_i with cnt_q == 0 is dropped: no rvalid_o, no pop.
- Push and pop in the same cycle: cnt_q is unchanged and the FIFO pointers both advance, wrapping modulo MAX_OUTSTANDING.
- cnt_q never exceeds MAX_OUTSTANDING and never underflows.

## Timing
- Reset values:
  - cnt_q=0, lock_q=0, FIFO pointers 0;
  - all outputs 0 while rst=1 and in the first cycle after reset with no req;
  - m_req_o, inst_gnt_o, data_gnt_o, inst_rvalid_o and data_rvalid_o are forced 0 during rst.
- Address path is combinational, 0 cycles: req_i -> m_req_o and m_gnt_i -> gnt_o in the same cycle.
- Response path is combinational, 0 cycles: m_rvalid_i -> rvalid_o in the same cycle.
- Registered state updates on the clock edge after the handshake or response.
- Full boundary: after the grant that makes cnt_q = MAX_OUTSTANDING, m_req_o=0 from the next cycle. It reasserts the cycle after the rvalid that decrements cnt_q.
- Reset mid-operation: FIFO, count and lock are cleared in one edge. Subsequent stray rvalids are dropped by the cnt_q==0 rule.

## Test plan
- Single inst read:
  - Stimulus: inst_req_i=1, inst_addr_i=0x100, m_gnt_i=1 in cycle 0; m_rvalid_i=1, m_rdata_i=0xDEADBEEF in cycle 2.
  - Required: cycle 0 m_addr_o=0x100, m_we_o=0, inst_gnt_o=1. Cycle 2 inst_rvalid_o=1, rdata_o=0xDEADBEEF, data_rvalid_o=0.
- Simultaneous requests:
  - Stimulus: inst and data req in cycle 0, data_addr_i=0x200, we=1, be=4'h3, m_gnt_i=1 always.
  - Required: cycle 0 data_gnt_o=1, m_addr_o=0x200, m_be_o=4'h3. Cycle 1 inst_gnt_o=1. Two rvalids route data first, then inst.
- Lock hold:
  - Stimulus: inst_req at 0x100 with m_gnt_i=0 for cycles 0-2; data_req rises in cycle 1; m_gnt_i=1 in cycle 3.
  - Required: m_addr_o=0x100 in cycles 0-3 and data_gnt_o=0 in those cycles. Cycle 3 inst_gnt_o=1. Cycle 4 data granted.
- Full stall (MAX_OUTSTANDING=2):
  - Stimulus: two data grants, no rvalid, third data_req held.
  - Required: m_req_o=0 and data_gnt_o=0 until the rvalid cycle. Third grant occurs the following cycle.
- Push/pop same cycle with error:
  - Stimulus: cnt_q=1 (inst), new data grant plus m_rvalid_i with m_err_i=1.
  - Required: inst_rvalid_o=1, err_o=1, cnt_q stays 1, and the head is now data.
- Reset mid-flight:
  - Stimulus: 2 outstanding, rst=1 for one cycle, then m_rvalid_i=1.
  - Required: cnt_q=0 and no rvalid_o asserted.
